// File: rtl/gaussian_nb_dbg_pkg.sv
// Shared definitions for the gaussian_nb debug infrastructure.
//   - Deadlock-reporter FSM state encodings (2-bit, legacy-compatible constants).
//   - Default qualification threshold and counter width.
package gaussian_nb_dbg_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_COUNT  = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam int DEF_THRESHOLD = 1024;
    localparam int DEF_CNT_W     = 32;

endpackage

// File: rtl/gaussian_nb_hls_deadlock_reporter_if.sv
// Report channel from the deadlock reporter to the debug/host collector.
//   rpt_valid      : report available (reporter -> collector)
//   rpt_ready      : collector accepts the report (collector -> reporter)
//   rpt_axis_mask  : AXIS channels blocked during the qualifying run
//   rpt_timestamp  : free-running cycle count at detection
// Modports: master = reporter side, slave = collector side.
interface gaussian_nb_hls_deadlock_reporter_if #(
    parameter int NUM_AXIS = 2,
    parameter int CNT_W    = 32
);
    logic                rpt_valid;
    logic                rpt_ready;
    logic [NUM_AXIS-1:0] rpt_axis_mask;
    logic [CNT_W-1:0]    rpt_timestamp;

    modport master (output rpt_valid, rpt_axis_mask, rpt_timestamp, input rpt_ready);
    modport slave  (input rpt_valid, rpt_axis_mask, rpt_timestamp, output rpt_ready);
endinterface

// File: rtl/gaussian_nb_dbg_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clock, reset : clock, synchronous active-high reset
//   clear        : zero the count (wins over enable)
//   en           : count one step this cycle
//   count        : current value, sticks at all-ones
module gaussian_nb_dbg_sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (en && (count != '1))
            count <= count + W'(1);
    end
endmodule

// File: rtl/gaussian_nb_hls_deadlock_reporter.sv
// Qualifies the deadlock monitor's per-cycle block indication with a
// consecutive-cycle threshold, latches a sticky deadlock flag, and issues a
// one-shot report (blocked AXIS channels + timestamp) over valid/ready.
//   clock, reset     : clock, synchronous active-high reset
//   block_in         : monitor block output, 1 = blocked this cycle
//   axis_block_sigs  : per-channel AXIS block flags, same timing as block_in
//   clear            : software clear of the sticky flag, report and stats
//   deadlock         : sticky deadlock flag
//   blocked_total    : saturating count of blocked cycles since reset/clear
//   rpt              : report channel (master side)
module gaussian_nb_hls_deadlock_reporter
    import gaussian_nb_dbg_pkg::*;
#(
    parameter int NUM_AXIS  = 2,
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                block_in,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic                clear,
    output logic                deadlock,
    output logic [CNT_W-1:0]    blocked_total,
    gaussian_nb_hls_deadlock_reporter_if.master rpt
);
    localparam logic [CNT_W-1:0] TH = CNT_W'(THRESHOLD);

    logic [1:0]          state;
    logic [CNT_W-1:0]    run_cnt;
    logic [CNT_W-1:0]    ts;
    logic [NUM_AXIS-1:0] mask;

    // Detection condition for this edge and the mask that goes into the report.
    // The current cycle's channel flags always belong to the qualifying run.
    logic                hit;
    logic [NUM_AXIS-1:0] hit_mask;

    always_comb begin
        hit      = 1'b0;
        hit_mask = axis_block_sigs;
        if (state == ST_IDLE) begin
            hit = block_in && (THRESHOLD == 1);
        end else if (state == ST_COUNT) begin
            hit      = block_in && ((run_cnt + CNT_W'(1)) == TH);
            hit_mask = mask | axis_block_sigs;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= ST_IDLE;
            run_cnt           <= '0;
            mask              <= '0;
            ts                <= '0;
            deadlock          <= 1'b0;
            rpt.rpt_valid     <= 1'b0;
            rpt.rpt_axis_mask <= '0;
            rpt.rpt_timestamp <= '0;
        end else begin
            ts <= ts + CNT_W'(1);   // free-running, untouched by clear
            if (clear) begin
                state             <= ST_IDLE;
                run_cnt           <= '0;
                mask              <= '0;
                deadlock          <= 1'b0;
                rpt.rpt_valid     <= 1'b0;
                rpt.rpt_axis_mask <= '0;
                rpt.rpt_timestamp <= '0;
            end else if (hit) begin
                state             <= ST_REPORT;
                mask              <= hit_mask;
                if (state == ST_IDLE) run_cnt <= CNT_W'(1);
                deadlock          <= 1'b1;
                rpt.rpt_valid     <= 1'b1;
                rpt.rpt_axis_mask <= hit_mask;
                rpt.rpt_timestamp <= ts;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (block_in) begin
                            state   <= ST_COUNT;
                            run_cnt <= CNT_W'(1);
                            mask    <= axis_block_sigs;
                        end
                    end
                    ST_COUNT: begin
                        if (block_in) begin
                            run_cnt <= run_cnt + CNT_W'(1);
                            mask    <= mask | axis_block_sigs;
                        end else begin
                            // Run broken: discard the partial mask.
                            state   <= ST_IDLE;
                            run_cnt <= '0;
                            mask    <= '0;
                        end
                    end
                    ST_REPORT: begin
                        if (rpt.rpt_ready) begin
                            state         <= ST_HOLD;
                            rpt.rpt_valid <= 1'b0;
                        end
                    end
                    default: ;  // HOLD: sticky until clear
                endcase
            end
        end
    end

    gaussian_nb_dbg_sat_counter #(.W(CNT_W)) u_total (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .en    (block_in),
        .count (blocked_total)
    );
endmodule

// File: tb/tb_gaussian_nb_hls_deadlock_reporter.sv
module tb_gaussian_nb_hls_deadlock_reporter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Instance 0: THRESHOLD=4, CNT_W=32. Instance 1: THRESHOLD=1, CNT_W=32.
    // Instance 2: THRESHOLD=3, CNT_W=4.
    localparam int TH[3] = '{4, 1, 3};
    localparam logic [31:0] WM[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};

    logic       blk[3];
    logic [1:0] ax[3];
    logic       clr[3];
    logic       rdy[3];

    logic        dl0, dl1, dl2;
    logic [31:0] tot0, tot1;
    logic [3:0]  tot2;

    gaussian_nb_hls_deadlock_reporter_if #(.NUM_AXIS(2), .CNT_W(32)) if0 ();
    gaussian_nb_hls_deadlock_reporter_if #(.NUM_AXIS(2), .CNT_W(32)) if1 ();
    gaussian_nb_hls_deadlock_reporter_if #(.NUM_AXIS(2), .CNT_W(4))  if2 ();
    assign if0.rpt_ready = rdy[0];
    assign if1.rpt_ready = rdy[1];
    assign if2.rpt_ready = rdy[2];

    gaussian_nb_hls_deadlock_reporter #(.NUM_AXIS(2), .THRESHOLD(4), .CNT_W(32)) dut0 (
        .clock(clock), .reset(reset), .block_in(blk[0]), .axis_block_sigs(ax[0]),
        .clear(clr[0]), .deadlock(dl0), .blocked_total(tot0), .rpt(if0.master));
    gaussian_nb_hls_deadlock_reporter #(.NUM_AXIS(2), .THRESHOLD(1), .CNT_W(32)) dut1 (
        .clock(clock), .reset(reset), .block_in(blk[1]), .axis_block_sigs(ax[1]),
        .clear(clr[1]), .deadlock(dl1), .blocked_total(tot1), .rpt(if1.master));
    gaussian_nb_hls_deadlock_reporter #(.NUM_AXIS(2), .THRESHOLD(3), .CNT_W(4)) dut2 (
        .clock(clock), .reset(reset), .block_in(blk[2]), .axis_block_sigs(ax[2]),
        .clear(clr[2]), .deadlock(dl2), .blocked_total(tot2), .rpt(if2.master));

    logic [31:0] o_dl[3], o_v[3], o_mask[3], o_ts[3], o_tot[3];
    assign o_dl[0] = 32'(dl0);  assign o_dl[1] = 32'(dl1);  assign o_dl[2] = 32'(dl2);
    assign o_v[0] = 32'(if0.rpt_valid); assign o_v[1] = 32'(if1.rpt_valid); assign o_v[2] = 32'(if2.rpt_valid);
    assign o_mask[0] = 32'(if0.rpt_axis_mask); assign o_mask[1] = 32'(if1.rpt_axis_mask);
    assign o_mask[2] = 32'(if2.rpt_axis_mask);
    assign o_ts[0] = if0.rpt_timestamp; assign o_ts[1] = if1.rpt_timestamp;
    assign o_ts[2] = 32'(if2.rpt_timestamp);
    assign o_tot[0] = tot0; assign o_tot[1] = tot1; assign o_tot[2] = 32'(tot2);

    int n_tests = 0;
    int n_fail  = 0;
    logic started = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: "deadlock once THRESHOLD blocked cycles occur in a row,
    // report until accepted, then stay silent until clear".
    int unsigned m_run[3];
    logic [1:0]  m_acc[3], m_mask[3];
    logic        m_dl[3], m_v[3];
    logic [31:0] m_ts[3], m_tsr[3], m_tot[3];

    always @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            int unsigned run;
            logic [1:0]  acc;
            run = m_run[k];
            acc = m_acc[k];
            if (reset) begin
                m_ts[k] <= 0; m_run[k] <= 0; m_acc[k] <= 0; m_mask[k] <= 0;
                m_dl[k] <= 0; m_v[k] <= 0; m_tsr[k] <= 0; m_tot[k] <= 0;
            end else begin
                m_ts[k] <= (m_ts[k] + 1) & WM[k];
                if (clr[k]) begin
                    m_run[k] <= 0; m_acc[k] <= 0; m_mask[k] <= 0;
                    m_dl[k] <= 0; m_v[k] <= 0; m_tsr[k] <= 0; m_tot[k] <= 0;
                end else begin
                    if (blk[k] && m_tot[k] != WM[k]) m_tot[k] <= m_tot[k] + 1;
                    if (!m_dl[k]) begin
                        if (blk[k]) begin
                            run = run + 1;
                            acc = acc | ax[k];
                            if (run == TH[k]) begin
                                m_dl[k] <= 1; m_v[k] <= 1;
                                m_mask[k] <= acc; m_tsr[k] <= m_ts[k];
                            end
                        end else begin
                            run = 0;
                            acc = 0;
                        end
                        m_run[k] <= run;
                        m_acc[k] <= acc;
                    end else if (m_v[k] && rdy[k]) begin
                        m_v[k] <= 0;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("m%0d deadlock", k), o_dl[k], 32'(m_dl[k]));
                chk($sformatf("m%0d rpt_valid", k), o_v[k], 32'(m_v[k]));
                chk($sformatf("m%0d rpt_axis_mask", k), o_mask[k], 32'(m_mask[k]));
                chk($sformatf("m%0d rpt_timestamp", k), o_ts[k], m_tsr[k]);
                chk($sformatf("m%0d blocked_total", k), o_tot[k], m_tot[k]);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] exp_ts;

    initial begin
        for (int k = 0; k < 3; k++) begin
            blk[k] = 0; ax[k] = 0; clr[k] = 0; rdy[k] = 0;
        end
        step();
        started = 1'b1;
        chk("reset deadlock", o_dl[0], 0);
        chk("reset rpt_valid", o_v[0], 0);
        chk("reset blocked_total", o_tot[0], 0);
        chk("reset rpt_timestamp", o_ts[0], 0);
        step();
        reset = 1'b0;

        // THRESHOLD=1: single pulse sampled while ts=7.
        for (int i = 0; i < 20 && m_ts[1] != 7; i++) step();
        blk[1] = 1; ax[1] = 2'b01;
        step();
        blk[1] = 0; ax[1] = 0;
        chk("th1 rpt_timestamp", o_ts[1], 7);
        chk("th1 rpt_valid", o_v[1], 1);
        chk("th1 rpt_axis_mask", o_mask[1], 1);
        rdy[1] = 1;
        step();
        rdy[1] = 0;
        chk("th1 valid after hs", o_v[1], 0);
        chk("th1 deadlock sticky", o_dl[1], 1);

        // THRESHOLD=4: 01,01,10,10 -> report with mask 11 right after 4th edge.
        blk[0] = 1; ax[0] = 2'b01;
        step(); step();
        ax[0] = 2'b10;
        step();
        chk("t1 no early deadlock", o_dl[0], 0);
        step();
        blk[0] = 0; ax[0] = 0;
        chk("t1 deadlock", o_dl[0], 1);
        chk("t1 rpt_valid", o_v[0], 1);
        chk("t1 rpt_axis_mask", o_mask[0], 3);
        chk("t1 blocked_total", o_tot[0], 4);
        rdy[0] = 1; step(); rdy[0] = 0;
        clr[0] = 1; step(); clr[0] = 0;
        chk("t1 clear deadlock", o_dl[0], 0);
        chk("t1 clear total", o_tot[0], 0);

        // Broken run 1,1,1,0,1,1,1: no detection, mask restarts after the gap.
        for (int i = 0; i < 7; i++) begin
            blk[0] = (i != 3);
            ax[0]  = (i < 3) ? 2'b01 : 2'b10;
            step();
            chk("t2 no deadlock", o_dl[0], 0);
        end
        chk("t2 blocked_total", o_tot[0], 6);
        blk[0] = 1; ax[0] = 2'b10;
        step();
        blk[0] = 0; ax[0] = 0;
        chk("t2 late deadlock", o_dl[0], 1);
        chk("t2 restarted mask", o_mask[0], 2);
        chk("t2 total", o_tot[0], 7);
        clr[0] = 1; step(); clr[0] = 0;

        // Backpressured report: payload holds for 10 cycles, one report only.
        blk[0] = 1; ax[0] = 2'b11;
        for (int i = 0; i < 4; i++) step();
        ax[0] = 2'b00;
        for (int i = 0; i < 10; i++) begin
            chk("t3 valid held", o_v[0], 1);
            chk("t3 mask held", o_mask[0], 3);
            step();
        end
        rdy[0] = 1;
        step();
        rdy[0] = 0;
        chk("t3 valid dropped", o_v[0], 0);
        chk("t3 deadlock sticky", o_dl[0], 1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t3 no second report", o_v[0], 0);
        end
        blk[0] = 0;
        clr[0] = 1; step(); clr[0] = 0;

        // clear with rpt_ready in REPORT: clear wins, then a fresh report.
        blk[0] = 1; ax[0] = 2'b01;
        for (int i = 0; i < 4; i++) step();
        blk[0] = 0;
        chk("t5 in report", o_v[0], 1);
        clr[0] = 1; rdy[0] = 1;
        step();
        clr[0] = 0; rdy[0] = 0;
        chk("t5 clr deadlock", o_dl[0], 0);
        chk("t5 clr valid", o_v[0], 0);
        chk("t5 clr mask", o_mask[0], 0);
        chk("t5 clr ts", o_ts[0], 0);
        chk("t5 clr total", o_tot[0], 0);
        blk[0] = 1; ax[0] = 2'b10;
        for (int i = 0; i < 3; i++) step();
        exp_ts = m_ts[0];
        step();
        blk[0] = 0; ax[0] = 0;
        chk("t5 fresh valid", o_v[0], 1);
        chk("t5 fresh ts", o_ts[0], exp_ts);
        chk("t5 fresh mask", o_mask[0], 2);

        // CNT_W=4: saturation after 20 blocked cycles; clear+block together.
        blk[2] = 1; ax[2] = 2'b01;
        for (int i = 0; i < 20; i++) step();
        chk("t6 saturated", o_tot[2], 15);
        chk("t6 deadlock", o_dl[2], 1);
        clr[2] = 1;
        step();
        clr[2] = 0;
        chk("t6 clear wins total", o_tot[2], 0);
        chk("t6 clear wins dl", o_dl[2], 0);
        step();
        chk("t6 count resumes", o_tot[2], 1);
        for (int i = 0; i < 2; i++) step();
        chk("t6 redetect", o_dl[2], 1);
        blk[2] = 0;

        // Reset mid-operation.
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst dl0", o_dl[0], 0);
        chk("rst dl1", o_dl[1], 0);
        chk("rst tot2", o_tot[2], 0);
        chk("rst ts0", o_ts[0], 0);
        for (int i = 0; i < 3; i++) step();

        started = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
